// File: rtl/rotary_pkg.sv
// Shared definitions for rotary-encoder consumers: UI state encoding and per-cycle
// input qualification (Press dominates; simultaneous Left and Right are dropped).
package rotary_pkg;

  localparam logic ST_SELECT = 1'b0;
  localparam logic ST_EDIT   = 1'b1;

  typedef enum logic {
    StSelect = ST_SELECT,
    StEdit   = ST_EDIT
  } ui_state_e;

  typedef enum logic [1:0] {
    StepNone  = 2'd0,
    StepInc   = 2'd1,
    StepDec   = 2'd2,
    StepPress = 2'd3
  } step_e;

  function automatic step_e qualify_step(logic press, logic left, logic right);
    if (press) begin
      return StepPress;
    end else if (right && !left) begin
      return StepInc;
    end else if (left && !right) begin
      return StepDec;
    end
    return StepNone;
  endfunction

endpackage

// File: rtl/sat_updown_reg.sv
// Saturating up/down register; steps by one within [MIN_VAL, MAX_VAL] when enabled.
// changed flags that the enabled step will actually alter the stored value.
module sat_updown_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 255,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             changed
);

  localparam logic [WIDTH:0]   MinExt = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   OneExt = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   q_ext, q_plus, q_next;

  // One extra bit keeps MAX_VAL = 2**WIDTH-1 from wrapping before the clamp.
  always_comb begin
    q_ext  = {1'b0, q_q};
    q_plus = q_ext + OneExt;
    q_next = q_ext;
    if (en && inc && !dec) begin
      q_next = (q_plus > MaxExt) ? MaxExt : q_plus;
    end else if (en && dec && !inc) begin
      q_next = (q_ext <= MinExt) ? MinExt : (q_ext - OneExt);
    end
    q_d     = q_next[WIDTH-1:0];
    changed = (q_d != q_q);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rotary_setpoint_controller.sv
// Two-level rotary UI: SELECT moves the field cursor, EDIT steps the selected setpoint,
// with an idle timeout that drops back to SELECT.
module rotary_setpoint_controller
  import rotary_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MIN_VAL    = 0,
  parameter int unsigned MAX_VAL    = 255,
  parameter int unsigned RESET_VAL  = 0,
  parameter int unsigned TIMEOUT    = 50_000_000
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Left,
  input  logic                          Right,
  input  logic                          Press,
  output logic [$clog2(NUM_FIELDS)-1:0] Field_sel,
  output logic                          Editing,
  output logic [NUM_FIELDS*WIDTH-1:0]   Values,
  output logic                          Update
);

  localparam int unsigned SelW = $clog2(NUM_FIELDS);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  ui_state_e       state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            update_q, update_d;

  step_e           step;
  logic            step_inc, step_dec;
  logic [NUM_FIELDS-1:0] field_en, field_changed;

  assign step     = qualify_step(Press, Left, Right);
  assign step_inc = (step == StepInc);
  assign step_dec = (step == StepDec);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StSelect: begin
        cnt_d = '0;
        if (step == StepPress) begin
          state_d = StEdit;
        end else if (step_inc) begin
          sel_d = sel_q + 1'b1;
        end else if (step_dec) begin
          sel_d = sel_q - 1'b1;
        end
      end
      StEdit: begin
        // Any qualified input on the expiry cycle takes priority over the timeout.
        if (step == StepPress) begin
          state_d = StSelect;
          cnt_d   = '0;
        end else if (step_inc || step_dec) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StSelect;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign field_en[k] = (state_q == StEdit) && (sel_q == SelW'(k));

    sat_updown_reg #(
      .WIDTH    (WIDTH),
      .MIN_VAL  (MIN_VAL),
      .MAX_VAL  (MAX_VAL),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .inc    (step_inc),
      .dec    (step_dec),
      .en     (field_en[k]),
      .q      (Values[k*WIDTH +: WIDTH]),
      .changed(field_changed[k])
    );
  end

  assign update_d = |field_changed;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= StSelect;
      sel_q    <= '0;
      cnt_q    <= '0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      update_q <= update_d;
    end
  end

  assign Field_sel = sel_q;
  assign Editing   = (state_q == StEdit);
  assign Update    = update_q;

endmodule

// File: tb/tb_rotary_setpoint_controller.sv
// Randomized and directed bench for rotary_setpoint_controller against a behavioural model.
module tb_rotary_setpoint_controller;

  localparam int NF   = 4;
  localparam int W    = 8;
  localparam int MINV = 0;
  localparam int MAXV = 255;
  localparam int RSTV = 0;
  localparam int TO   = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Left = 1'b0;
  logic        Right = 1'b0;
  logic        Press = 1'b0;
  logic [1:0]  Field_sel;
  logic        Editing;
  logic [31:0] Values;
  logic        Update;

  rotary_setpoint_controller #(
    .NUM_FIELDS(NF),
    .WIDTH     (W),
    .MIN_VAL   (MINV),
    .MAX_VAL   (MAXV),
    .RESET_VAL (RSTV),
    .TIMEOUT   (TO)
  ) u_dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Left     (Left),
    .Right    (Right),
    .Press    (Press),
    .Field_sel(Field_sel),
    .Editing  (Editing),
    .Values   (Values),
    .Update   (Update)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int upd_seen = 0;

  // Behavioural model: field values, cursor, mode, consecutive idle cycles in EDIT.
  int m_vals[NF];
  int m_sel;
  bit m_edit;
  int m_idle;
  bit m_upd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_step(bit rst_n, bit p, bit l, bit r);
    int nv;
    m_upd = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < NF; k++) m_vals[k] = RSTV;
      m_sel  = 0;
      m_edit = 1'b0;
      m_idle = 0;
    end else if (p) begin
      m_edit = !m_edit;
      m_idle = 0;
    end else if (l != r) begin
      if (!m_edit) begin
        m_sel = (m_sel + (r ? 1 : NF - 1)) % NF;
      end else begin
        m_idle = 0;
        nv = m_vals[m_sel] + (r ? 1 : -1);
        if (nv > MAXV) nv = MAXV;
        if (nv < MINV) nv = MINV;
        if (nv != m_vals[m_sel]) begin
          m_vals[m_sel] = nv;
          m_upd = 1'b1;
        end
      end
    end else if (m_edit) begin
      m_idle++;
      if (m_idle == TO) begin
        m_edit = 1'b0;
        m_idle = 0;
      end
    end
  endfunction

  task automatic cycle(input bit rst_n, input bit p, input bit l, input bit r);
    logic [31:0] exp_v;
    Reset_n = rst_n;
    Press   = p;
    Left    = l;
    Right   = r;
    @(posedge Clk);
    #1;
    model_step(rst_n, p, l, r);
    if (Update === 1'b1) upd_seen++;
    for (int k = 0; k < NF; k++) exp_v[k*W +: W] = 8'(m_vals[k]);
    check_val("field_sel", 32'(Field_sel), 32'(m_sel));
    check_val("editing", 32'(Editing), 32'(m_edit));
    check_val("update", 32'(Update), 32'(m_upd));
    check_val("values", Values, exp_v);
    Reset_n = 1'b1;
    Press   = 1'b0;
    Left    = 1'b0;
    Right   = 1'b0;
  endtask

  initial begin
    // 1: reset, then cursor walk with wrap
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("reset_sel", 32'(Field_sel), 32'd0);
    check_val("reset_values", Values, 32'd0);
    upd_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
    check_val("s1_sel", 32'(Field_sel), 32'd1);
    check_val("s1_updates", 32'(upd_seen), 32'd0);

    // 2: edit field 1
    upd_seen = 0;
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 0);
    check_val("s2_field1", 32'(Values[15:8]), 32'd2);
    check_val("s2_updates", 32'(upd_seen), 32'd4);
    check_val("s2_editing", 32'(Editing), 32'd1);
    check_val("s2_others", {Values[31:16], Values[7:0]}, 32'd0);

    // 3: saturation at both ends on field 0
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 1, 0, 0);
    upd_seen = 0;
    cycle(1, 0, 1, 0);
    check_val("s3_min_sat_upd", 32'(upd_seen), 32'd0);
    for (int i = 0; i < 260; i++) cycle(1, 0, 0, 1);
    check_val("s3_field0", 32'(Values[7:0]), 32'd255);
    check_val("s3_updates", 32'(upd_seen), 32'd255);

    // 4: idle timeout, and a saturated Right on cycle 15 restarting it
    for (int i = 0; i < TO - 1; i++) cycle(1, 0, 0, 0);
    check_val("s4_before_to", 32'(Editing), 32'd1);
    cycle(1, 0, 0, 0);
    check_val("s4_timeout", 32'(Editing), 32'd0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < TO - 2; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    for (int i = 0; i < TO - 1; i++) cycle(1, 0, 0, 0);
    check_val("s4_restart_hold", 32'(Editing), 32'd1);
    cycle(1, 0, 0, 0);
    check_val("s4_restart_to", 32'(Editing), 32'd0);

    // 5: Press wins over Right; Left+Right dropped in EDIT
    cycle(1, 1, 0, 1);
    check_val("s5_sel", 32'(Field_sel), 32'd0);
    check_val("s5_edit", 32'(Editing), 32'd1);
    upd_seen = 0;
    cycle(1, 0, 1, 1);
    check_val("s5_both_upd", 32'(upd_seen), 32'd0);
    check_val("s5_both_val", 32'(Values[7:0]), 32'd255);
    cycle(1, 1, 0, 0);

    // 6: reset mid-edit discards everything
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 1);
    check_val("s6_field2", 32'(Values[23:16]), 32'd7);
    cycle(0, 0, 0, 0);
    check_val("s6_sel", 32'(Field_sel), 32'd0);
    check_val("s6_edit", 32'(Editing), 32'd0);
    check_val("s6_values", Values, 32'd0);

    // Random traffic; Right biased in half the run so the upper bound is reached too
    for (int i = 0; i < 4000; i++) begin
      bit rn, p, l, r;
      rn = ($urandom_range(0, 299) != 0);
      p  = ($urandom_range(0, 11) == 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        l = 1'b0;
        r = 1'b0;
      end
      cycle(rn, p, l, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
